// File: rtl/ped_signal_timer_if.sv
// Signal bundle between the crossing controller and the pedestrian phase timer.
// tick and force_req are strobes/levels sampled on clk; there is no valid/ready handshake on this bus.
interface ped_signal_timer_if #(
    parameter int CNT_W = 5
);
    logic             tick;
    logic             pause;
    logic             force_req;
    logic [1:0]       phase;
    logic             walk;
    logic             flash;
    logic             lamp;
    logic [CNT_W-1:0] second;
    logic             phase_done;

    modport master (
        output tick, pause, force_req,
        input  phase, walk, flash, lamp, second, phase_done
    );

    modport slave (
        input  tick, pause, force_req,
        output phase, walk, flash, lamp, second, phase_done
    );
endinterface

// File: rtl/ped_signal_timer.sv
// Pedestrian crossing phase timer: RED -> WALK -> CLEAR -> RED with programmable lengths.
// Optional macro RED_COUNTDOWN_EN: show the remaining RED time on second instead of 0.
module ped_signal_timer #(
    parameter int CNT_W     = 5,
    parameter int RED_LEN   = 5,
    parameter int WALK_LEN  = 7,
    parameter int CLEAR_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    ped_signal_timer_if.slave bus
);
    typedef enum logic [1:0] {
        RED   = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2,
        BAD   = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] RED_L   = CNT_W'(RED_LEN);
    localparam logic [CNT_W-1:0] WALK_L  = CNT_W'(WALK_LEN);
    localparam logic [CNT_W-1:0] CLEAR_L = CNT_W'(CLEAR_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    phase_t           state, state_n;
    logic [CNT_W-1:0] remain, remain_n;
    logic             blink, blink_n;
    logic             force_d;
    logic             done, done_n;
    logic             force_edge;

    assign force_edge = bus.force_req & ~force_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RED;
            remain  <= RED_L;
            blink   <= 1'b1;
            force_d <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            remain  <= remain_n;
            blink   <= blink_n;
            force_d <= bus.force_req;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        remain_n = remain;
        blink_n  = blink;
        done_n   = 1'b0;
        if (state == BAD) begin
            state_n  = RED;
            remain_n = RED_L;
            done_n   = 1'b1;
        end else if (force_edge) begin
            // A force edge also swallows any tick arriving in the same cycle.
            done_n = 1'b1;
            if (state == RED) begin
                state_n  = WALK;
                remain_n = WALK_L;
            end else begin
                state_n  = RED;
                remain_n = RED_L;
            end
        end else if (!bus.pause && bus.tick) begin
            if (remain == ONE) begin
                done_n = 1'b1;
                case (state)
                    RED: begin
                        state_n  = WALK;
                        remain_n = WALK_L;
                    end
                    WALK: begin
                        state_n  = CLEAR;
                        remain_n = CLEAR_L;
                        blink_n  = 1'b1;
                    end
                    default: begin
                        state_n  = RED;
                        remain_n = RED_L;
                    end
                endcase
            end else begin
                remain_n = remain - ONE;
                if (state == CLEAR) blink_n = ~blink;
            end
        end
    end

    always_comb begin
        bus.phase      = state;
        bus.walk       = (state == WALK) || (state == CLEAR);
        bus.flash      = (state == CLEAR);
        bus.lamp       = (state == WALK) || ((state == CLEAR) && blink);
        bus.phase_done = done;
        case (state)
            WALK:    bus.second = remain + CLEAR_L;
            CLEAR:   bus.second = remain;
`ifdef RED_COUNTDOWN_EN
            RED:     bus.second = remain;
`else
            RED:     bus.second = '0;
`endif
            default: bus.second = '0;
        endcase
    end
endmodule

// File: tb/tb_ped_signal_timer.sv
// Randomised bench for ped_signal_timer against a phase/elapsed-ticks reference model.
module tb_ped_signal_timer;
    localparam int CNT_W = 5;
`ifdef RED_COUNTDOWN_EN
    localparam bit RCD = 1'b1;
`else
    localparam bit RCD = 1'b0;
`endif

    logic clk;
    logic rst;
    ped_signal_timer_if #(.CNT_W(CNT_W)) bus_if ();

    ped_signal_timer #(.CNT_W(CNT_W), .RED_LEN(5), .WALK_LEN(7), .CLEAR_LEN(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    // Reference model: current phase and ticks already spent in it.
    int len [3] = '{5, 7, 3};
    int m_phase, m_elapsed;
    bit m_done, m_prev_force;

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_done = 0; m_prev_force = 0;
    endfunction

    function automatic void model_step(input bit t, input bit p, input bit f);
        bit edge_seen;
        edge_seen = f && !m_prev_force;
        m_prev_force = f;
        m_done = 0;
        if (edge_seen) begin
            m_phase = (m_phase == 0) ? 1 : 0;
            m_elapsed = 0;
            m_done = 1;
        end else if (!p && t) begin
            m_elapsed++;
            if (m_elapsed == len[m_phase]) begin
                m_phase = (m_phase + 1) % 3;
                m_elapsed = 0;
                m_done = 1;
            end
        end
    endfunction

    function automatic int exp_second();
        int left;
        left = len[m_phase] - m_elapsed;
        if (m_phase == 1) return left + len[2];
        if (m_phase == 2) return left;
        return RCD ? left : 0;
    endfunction

    task automatic compare_all(input string ctx);
        check({ctx, ":phase"}, 32'(bus_if.phase), 32'(m_phase));
        check({ctx, ":second"}, 32'(bus_if.second), 32'(exp_second()));
        check({ctx, ":walk"}, 32'(bus_if.walk), 32'(m_phase != 0));
        check({ctx, ":flash"}, 32'(bus_if.flash), 32'(m_phase == 2));
        check({ctx, ":lamp"}, 32'(bus_if.lamp),
              32'((m_phase == 1) || (m_phase == 2 && (m_elapsed % 2) == 0)));
        check({ctx, ":done"}, 32'(bus_if.phase_done), 32'(m_done));
    endtask

    task automatic step(input string ctx, input bit t, input bit p, input bit f);
        bus_if.tick = t; bus_if.pause = p; bus_if.force_req = f;
        @(posedge clk);
        model_step(t, p, f);
        #1;
        compare_all(ctx);
    endtask

    task automatic wait_for(input string ctx, input int ph, input int sec);
        int n;
        n = 0;
        while (!(m_phase == ph && exp_second() == sec) && n < 200) begin
            step(ctx, 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= 200) check({ctx, ":timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit f;
        rst = 1'b1;
        bus_if.tick = 1'b1; bus_if.pause = 1'b0; bus_if.force_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset:second_abs", 32'(bus_if.second), RCD ? 32'd5 : 32'd0);
        rst = 1'b0;

        // Free-running cycle from reset with a tick every clock.
        for (int i = 0; i < 18; i++) step("run", 1'b1, 1'b0, 1'b0);

        // Pause in WALK at second 8.
        wait_for("w8", 1, 8);
        check("w8:second_abs", 32'(bus_if.second), 32'd8);
        for (int i = 0; i < 4; i++) step("pause", 1'b1, 1'b1, 1'b0);
        step("resume", 1'b1, 1'b0, 1'b0);
        check("resume:second_abs", 32'(bus_if.second), 32'd7);

        // Force rising edge in RED, then held high: one advance only.
        wait_for("red", 0, RCD ? 4 : 0);
        step("force", 1'b1, 1'b0, 1'b1);
        check("force:phase_abs", 32'(bus_if.phase), 32'd1);
        for (int i = 0; i < 10; i++) step("force_hold", 1'b1, 1'b0, 1'b1);
        step("force_low", 1'b1, 1'b0, 1'b0);

        // Force edge coinciding with CLEAR expiry while paused.
        wait_for("clr1", 2, 1);
        step("force_clr", 1'b1, 1'b1, 1'b1);
        check("force_clr:phase_abs", 32'(bus_if.phase), 32'd0);
        step("force_clr2", 1'b1, 1'b1, 1'b1);
        step("force_clr3", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WALK.
        wait_for("walk9", 1, 9);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic.
        f = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) f = ~f;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
